// File: rtl/axi_tag_mem_slave_if.sv
// Bus bundle for the tag/data memory slave: AR/R read channels and AW/W/B write channels.
interface axi_tag_mem_slave_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int TAG_W  = 64,
  parameter int ID_W   = 16
);
  logic [ID_W-1:0]         arid_i;
  logic [ADDR_W-1:0]       araddr_i;
  logic                    arvalid_i;
  logic                    arready_o;
  logic [ID_W-1:0]         rid_o;
  logic [TAG_W+DATA_W-1:0] rdata_o;
  logic                    rvalid_o;
  logic                    rready_i;
  logic [ID_W-1:0]         awid_i;
  logic [ADDR_W-1:0]       awaddr_i;
  logic                    awdirty_i;
  logic                    awvalid_i;
  logic                    awready_o;
  logic [DATA_W-1:0]       wdata_i;
  logic                    wvalid_i;
  logic                    wready_o;
  logic [ID_W-1:0]         bid_o;
  logic                    bvalid_o;
  logic                    bready_i;

  modport slave (
    input  arid_i, araddr_i, arvalid_i, rready_i,
    input  awid_i, awaddr_i, awdirty_i, awvalid_i, wdata_i, wvalid_i, bready_i,
    output arready_o, rid_o, rdata_o, rvalid_o,
    output awready_o, wready_o, bid_o, bvalid_o
  );

  modport master (
    output arid_i, araddr_i, arvalid_i, rready_i,
    output awid_i, awaddr_i, awdirty_i, awvalid_i, wdata_i, wvalid_i, bready_i,
    input  arready_o, rid_o, rdata_o, rvalid_o,
    input  awready_o, wready_o, bid_o, bvalid_o
  );
endinterface

// File: rtl/axi_tag_mem_slave.sv
// Single-beat slave memory holding one tag word and one data line per cache index.
// Reads return {tag word, data line} after a fixed latency; unwritten entries read as zero.
module axi_tag_mem_slave #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int TAG_W    = 64,
  parameter int ID_W     = 16,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 6,
  parameter int RD_LAT   = 2
) (
  input logic                clk,
  input logic                rst_n,
  axi_tag_mem_slave_if.slave bus
);
  localparam int DEPTH  = 2**INDEX_W;
  localparam int TB     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W = TAG_W + DATA_W;
  // Counter preload: R_WAIT lasts RD_LAT cycles, capture happens when it reads zero.
  localparam logic [3:0] LAT_LOAD = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  // Tag word: {valid, dirty, tagbits, zero padding}.
  function automatic logic [TAG_W-1:0] make_tag(input logic dirty, input logic [TB-1:0] tagbits);
    logic [TAG_W-1:0] t;
    t = '0;
    t[TAG_W-1] = 1'b1;
    t[TAG_W-2] = dirty;
    t[TAG_W-3 -: TB] = tagbits;
    return t;
  endfunction

  // Offset bits only select bytes inside a line; the model stores whole lines.
  logic unused_offset;
  assign unused_offset = ^{bus.araddr_i[OFFSET_W-1:0], bus.awaddr_i[OFFSET_W-1:0]};

  // ---------------- write side ----------------
  wstate_e           w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q;
  logic [INDEX_W-1:0] w_idx_q;
  logic [TAG_W-1:0]  w_tag_q;
  logic              aw_hs, w_commit;

  assign aw_hs    = rst_n && bus.awvalid_i && (w_state_q == W_IDLE);
  assign w_commit = rst_n && bus.wvalid_i  && (w_state_q == W_DATA);

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) w_state_q <= W_IDLE;
    else        w_state_q <= w_state_d;
  end

  // Write FSM next state: address, then data, then response.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs)        w_state_d = W_DATA;
      W_DATA:  if (w_commit)     w_state_d = W_RESP;
      W_RESP:  if (bus.bready_i) w_state_d = W_IDLE;
      default:                   w_state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs; everything is forced low while reset is held.
  always_comb begin
    bus.awready_o = rst_n && (w_state_q == W_IDLE);
    bus.wready_o  = rst_n && (w_state_q == W_DATA);
    bus.bvalid_o  = rst_n && (w_state_q == W_RESP);
    bus.bid_o     = rst_n ? w_id_q : '0;
  end

  // Latch the write command so W can arrive on any later cycle.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      w_id_q  <= bus.awid_i;
      w_idx_q <= bus.awaddr_i[INDEX_W+OFFSET_W-1:OFFSET_W];
      w_tag_q <= make_tag(bus.awdirty_i, bus.awaddr_i[ADDR_W-1 -: TB]);
    end
  end

  // Commit tag and data arrays; these are never reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      tag_mem[w_idx_q]  <= w_tag_q;
      data_mem[w_idx_q] <= bus.wdata_i;
    end
  end

  // Per-index valid bits: cleared by reset, set by each committed write.
  always_ff @(posedge clk) begin
    if (!rst_n)        valid_q <= '0;
    else if (w_commit) valid_q[w_idx_q] <= 1'b1;
  end

  // ---------------- read side ----------------
  rstate_e            r_state_q, r_state_d;
  logic [ID_W-1:0]    r_id_q;
  logic [INDEX_W-1:0] r_idx_q;
  logic [3:0]         cnt_q;
  logic [LINE_W-1:0]  rdata_q;
  logic               ar_hs, capture;
  logic [INDEX_W-1:0] cap_idx;
  logic [LINE_W-1:0]  cap_line;

  assign ar_hs = rst_n && bus.arvalid_i && (r_state_q == R_IDLE);

  // Capture point: at the handshake itself for zero latency, else when the wait count expires.
  always_comb begin
    capture = 1'b0;
    cap_idx = r_idx_q;
    if (r_state_q == R_IDLE) begin
      capture = ar_hs && (RD_LAT == 0);
      cap_idx = bus.araddr_i[INDEX_W+OFFSET_W-1:OFFSET_W];
    end else if (r_state_q == R_WAIT) begin
      capture = (cnt_q == 4'd0);
    end
  end

  // Captured line; a write committing to the same index this cycle wins.
  always_comb begin
    cap_line = '0;
    if (w_commit && (w_idx_q == cap_idx)) cap_line = {w_tag_q, bus.wdata_i};
    else if (valid_q[cap_idx])            cap_line = {tag_mem[cap_idx], data_mem[cap_idx]};
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state_q <= R_IDLE;
    else        r_state_q <= r_state_d;
  end

  // Read FSM next state: accept, wait out the latency, hold the response.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs)          r_state_d = (RD_LAT == 0) ? R_DATA : R_WAIT;
      R_WAIT:  if (cnt_q == 4'd0)  r_state_d = R_DATA;
      R_DATA:  if (bus.rready_i)   r_state_d = R_IDLE;
      default:                     r_state_d = R_IDLE;
    endcase
  end

  // Read FSM outputs; everything is forced low while reset is held.
  always_comb begin
    bus.arready_o = rst_n && (r_state_q == R_IDLE);
    bus.rvalid_o  = rst_n && (r_state_q == R_DATA);
    bus.rid_o     = rst_n ? r_id_q  : '0;
    bus.rdata_o   = rst_n ? rdata_q : '0;
  end

  // Read command latch, latency counter and response data register.
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      r_id_q  <= bus.arid_i;
      r_idx_q <= bus.araddr_i[INDEX_W+OFFSET_W-1:OFFSET_W];
      cnt_q   <= LAT_LOAD;
    end else if ((r_state_q == R_WAIT) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
    if (capture) rdata_q <= cap_line;
  end
endmodule

// File: tb/tb_axi_tag_mem_slave.sv
// Randomised scoreboard bench for axi_tag_mem_slave with a per-index reference memory.
module tb_axi_tag_mem_slave;
  localparam int ADDR_W = 64, DATA_W = 512, TAG_W = 64, ID_W = 16;
  localparam int INDEX_W = 10, OFFSET_W = 6, RD_LAT = 2;
  localparam int LINE_W = TAG_W + DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_tag_mem_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .ID_W(ID_W)) bus ();

  axi_tag_mem_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .ID_W(ID_W),
    .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
  endtask

  // Reference memory: an entry exists only once written since the last reset.
  logic [TAG_W-1:0]  m_tag  [int];
  logic [DATA_W-1:0] m_data [int];

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'(a[15:6]);
  endfunction

  function automatic logic [TAG_W-1:0] tag_word(input logic [ADDR_W-1:0] a, input logic d);
    return {1'b1, d, a[63:16], 14'd0};
  endfunction

  function automatic logic [LINE_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    int i;
    i = idx_of(a);
    if (m_tag.exists(i)) return {m_tag[i], m_data[i]};
    return '0;
  endfunction

  function automatic void model_write(input logic [ADDR_W-1:0] a, input logic d, input logic [DATA_W-1:0] line);
    m_tag[idx_of(a)]  = tag_word(a, d);
    m_data[idx_of(a)] = line;
  endfunction

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  typedef struct { logic [ID_W-1:0] id; logic [LINE_W-1:0] data; int due; } rexp_t;
  typedef struct { logic [ID_W-1:0] id; int due; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];

  // Ready generators: 0 random, 1 held low, 2 held high.
  int rr_mode = 0;
  int br_mode = 0;
  initial begin
    bus.rready_i = 1'b0;
    bus.bready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.rready_i = (rr_mode == 0) ? 1'($urandom_range(0, 1)) : (rr_mode == 2);
      bus.bready_i = (br_mode == 0) ? 1'($urandom_range(0, 1)) : (br_mode == 2);
    end
  end

  // Monitor: protocol checks and scoreboard pops.
  logic prv_rv = 1'b0, prv_rr = 1'b0, prv_hs = 1'b0, prv_bv = 1'b0, prv_rst = 1'b0;
  logic [LINE_W-1:0] prv_rd = '0;
  logic [ID_W-1:0]   prv_rid = '0;
  initial begin
    rexp_t re;
    bexp_t be;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_ctl_zero", LINE_W'({bus.arready_o, bus.awready_o, bus.wready_o, bus.rvalid_o,
                                        bus.bvalid_o, bus.rid_o, bus.bid_o}), '0);
        check("reset_rdata_zero", bus.rdata_o, '0);
        prv_rv = 1'b0; prv_rr = 1'b0; prv_hs = 1'b0; prv_bv = 1'b0; prv_rst = 1'b1;
      end else begin
        if (prv_rst) check("ready_after_reset", LINE_W'({bus.arready_o, bus.awready_o}), LINE_W'(2'b11));
        prv_rst = 1'b0;
        if (prv_hs) check("arready_after_r", LINE_W'(bus.arready_o), LINE_W'(1'b1));
        if (bus.rvalid_o) begin
          check("arready_low_in_rdata", LINE_W'(bus.arready_o), '0);
          if (!prv_rv) begin
            if (rq.size() == 0) fail_event("unexpected_rvalid");
            else check("rvalid_latency", LINE_W'(cyc), LINE_W'(rq[0].due));
          end else if (!prv_rr) begin
            check("rdata_hold", bus.rdata_o, prv_rd);
            check("rid_hold", LINE_W'(bus.rid_o), LINE_W'(prv_rid));
          end
          if (bus.rready_i && rq.size() != 0) begin
            re = rq.pop_front();
            check("rid", LINE_W'(bus.rid_o), LINE_W'(re.id));
            check("rdata", bus.rdata_o, re.data);
          end
        end
        if (bus.bvalid_o) begin
          if (!prv_bv) begin
            if (bq.size() == 0) fail_event("unexpected_bvalid");
            else check("bvalid_latency", LINE_W'(cyc), LINE_W'(bq[0].due));
          end
          if (bus.bready_i && bq.size() != 0) begin
            be = bq.pop_front();
            check("bid", LINE_W'(bus.bid_o), LINE_W'(be.id));
          end
        end
        prv_hs = bus.rvalid_o && bus.rready_i;
        prv_rv = bus.rvalid_o;
        prv_rr = bus.rready_i;
        prv_rd = bus.rdata_o;
        prv_rid = bus.rid_o;
        prv_bv = bus.bvalid_o;
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      fail_event("drain_timeout");
      rq.delete();
      bq.delete();
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic d, input logic [ID_W-1:0] id,
                          input logic [DATA_W-1:0] line);
    int n;
    @(posedge clk); #1;
    bus.awaddr_i = a; bus.awdirty_i = d; bus.awid_i = id; bus.awvalid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.awready_o && n < 50) begin @(negedge clk); n++; end
    if (!bus.awready_o) begin fail_event("aw_accept_timeout"); bus.awvalid_i = 1'b0; return; end
    @(posedge clk); #1;
    bus.awvalid_i = 1'b0;
    bus.wdata_i = line; bus.wvalid_i = 1'b1;
    @(negedge clk);
    check("wready_after_aw", LINE_W'(bus.wready_o), LINE_W'(1'b1));
    n = 0;
    while (!bus.wready_o && n < 50) begin @(negedge clk); n++; end
    if (!bus.wready_o) begin fail_event("w_accept_timeout"); bus.wvalid_i = 1'b0; return; end
    model_write(a, d, line);
    bq.push_back('{id: id, due: cyc + 1});
    @(posedge clk); #1;
    bus.wvalid_i = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id, input bit wait_done);
    int n;
    @(posedge clk); #1;
    bus.araddr_i = a; bus.arid_i = id; bus.arvalid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.arready_o && n < 50) begin @(negedge clk); n++; end
    if (!bus.arready_o) begin fail_event("ar_accept_timeout"); bus.arvalid_i = 1'b0; return; end
    rq.push_back('{id: id, data: model_read(a), due: cyc + 1 + RD_LAT});
    @(posedge clk); #1;
    bus.arvalid_i = 1'b0;
    if (wait_done) wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] line;
    logic [47:0] tpool [3];
    bus.arid_i = '0; bus.araddr_i = '0; bus.arvalid_i = 1'b0;
    bus.awid_i = '0; bus.awaddr_i = '0; bus.awdirty_i = 1'b0; bus.awvalid_i = 1'b0;
    bus.wdata_i = '0; bus.wvalid_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Read of never-written index returns zeros with the echoed ID.
    do_read(64'h0000_0000_0001_2340, 16'h5, 1);

    // Write with dirty set, then read it back.
    do_write(64'h0000_00AB_CDEF_0040, 1'b1, 16'h7, rand_line());
    do_read(64'h0000_00AB_CDEF_0040, 16'h11, 1);

    // Overwrite index 5 with different tagbits and clean; read through the aliased address.
    do_write({48'h1111_2222_3333, 10'd5, 6'd0}, 1'b1, 16'h21, rand_line());
    do_write({48'h4444_5555_6666, 10'd5, 6'd3}, 1'b0, 16'h22, rand_line());
    do_read({48'h1111_2222_3333, 10'd5, 6'd0}, 16'h23, 1);

    // Backpressure on R for more than ten cycles.
    rr_mode = 1;
    do_read({48'h4444_5555_6666, 10'd5, 6'd0}, 16'h31, 0);
    repeat (14) @(posedge clk);
    rr_mode = 2;
    wait_drain();
    rr_mode = 0;

    // Same-index write commit in the read's capture cycle.
    do_write({48'hAAAA_0000_0001, 10'd9, 6'd0}, 1'b0, 16'h40, rand_line());
    wait_drain();
    a = {48'hBBBB_0000_0002, 10'd9, 6'd8};
    line = rand_line();
    @(posedge clk); #1;
    bus.araddr_i = a; bus.arid_i = 16'h41; bus.arvalid_i = 1'b1;
    bus.awaddr_i = a; bus.awid_i = 16'h42; bus.awdirty_i = 1'b1; bus.awvalid_i = 1'b1;
    @(negedge clk);
    check("conc_ready", LINE_W'({bus.arready_o, bus.awready_o}), LINE_W'(2'b11));
    model_write(a, 1'b1, line);
    rq.push_back('{id: 16'h41, data: model_read(a), due: cyc + 1 + RD_LAT});
    @(posedge clk); #1;
    bus.arvalid_i = 1'b0; bus.awvalid_i = 1'b0;
    @(posedge clk); #1;
    bus.wdata_i = line; bus.wvalid_i = 1'b1;
    @(negedge clk);
    check("conc_wready", LINE_W'(bus.wready_o), LINE_W'(1'b1));
    bq.push_back('{id: 16'h42, due: cyc + 1});
    @(posedge clk); #1;
    bus.wvalid_i = 1'b0;
    wait_drain();

    // Reset while B is pending and a read is waiting; entries must be invalid afterwards.
    br_mode = 1;
    a = {48'hCCCC_DDDD_EEEE, 10'd17, 6'd0};
    do_write(a, 1'b1, 16'h51, rand_line());
    do_read(a, 16'h52, 0);
    rst_n = 1'b0;
    rq.delete();
    bq.delete();
    m_tag.delete();
    m_data.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    br_mode = 0;
    do_read(a, 16'h53, 1);
    do_read(64'h0000_00AB_CDEF_0040, 16'h54, 1);

    // Randomised mix over a few indices and aliasing tags.
    for (int k = 0; k < 3; k++) tpool[k] = 48'({$urandom, $urandom});
    for (int k = 0; k < 40; k++) begin
      a = {tpool[$urandom_range(0, 2)], 10'($urandom_range(0, 5)), 6'($urandom)};
      if ($urandom_range(0, 1) == 1) do_write(a, 1'($urandom), 16'($urandom), rand_line());
      else                           do_read(a, 16'($urandom), 1);
    end
    wait_drain();
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
